rx_align_ctrl: RTL and testbench

RX_ALIGN_CTRL -- requirements
Module: rx_align_ctrl

---
 rtl/rx_align_ctrl.sv | 145 ++++++++++++++
 tb/tb_rx_align_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_align_ctrl.sv
// rx_align_ctrl: RX PLL bring-up, clock-lane word alignment by bitslip,
// and loss-of-alignment monitoring for an LVDS deserializer.
module rx_align_ctrl #(
  parameter int unsigned P_PLL_RST_CYC  = 10,
  parameter int unsigned P_LOCK_TIMEOUT = 4096,
  parameter logic [6:0]  P_PATTERN      = 7'b1100011,
  parameter int unsigned P_MATCH_CNT    = 16,
  parameter int unsigned P_SETTLE_CYC   = 4,
  parameter int unsigned P_LOSS_CNT     = 4
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_pll_lock,
  input  logic [6:0] I_clk_word,
  output logic       O_pll_rst,
  output logic       O_bitslip,
  output logic       O_aligned,
  output logic       O_rst,
  output logic [2:0] O_slip_cnt,
  output logic       O_err
);

  localparam int unsigned CMAX_A =
    (P_LOCK_TIMEOUT > P_PLL_RST_CYC) ? P_LOCK_TIMEOUT : P_PLL_RST_CYC;
  localparam int unsigned CMAX =
    (CMAX_A > P_SETTLE_CYC) ? CMAX_A : P_SETTLE_CYC;
  localparam int unsigned CW = $clog2(CMAX + 1);
  localparam int unsigned MW = $clog2(P_MATCH_CNT + 1);
  localparam int unsigned LW = $clog2(P_LOSS_CNT + 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_CHECK,
    S_SLIP,
    S_SETTLE,
    S_ALIGNED
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [MW-1:0] match_q;
  logic [LW-1:0] loss_q;
  logic [2:0]    slip_q;
  logic          pll_rst_q;
  logic          bitslip_q;
  logic          aligned_q;
  logic          dp_rst_q;
  logic          err_q;
  logic          match;
  logic          lock_lost;

  assign match     = (I_clk_word == P_PATTERN);
  assign lock_lost = !I_pll_lock &&
    (state_q inside {S_CHECK, S_SLIP, S_SETTLE, S_ALIGNED});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_PLL_RST:
        if (cnt_q == CW'(P_PLL_RST_CYC - 1))
          state_d = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (I_pll_lock)
          state_d = S_CHECK;
        else if (cnt_q == CW'(P_LOCK_TIMEOUT - 1))
          state_d = S_PLL_RST;
      S_CHECK:
        if (!match)
          state_d = S_SLIP;
        else if (match_q == MW'(P_MATCH_CNT - 1))
          state_d = S_ALIGNED;
      // A SLIP visit without a pulse means all 7 phases were tried
      S_SLIP:
        state_d = bitslip_q ? S_SETTLE : S_PLL_RST;
      S_SETTLE:
        if (cnt_q == CW'(P_SETTLE_CYC - 1))
          state_d = S_CHECK;
      S_ALIGNED:
        if (!match && loss_q == LW'(P_LOSS_CNT - 1))
          state_d = S_CHECK;
      default:
        state_d = S_PLL_RST;
    endcase
    if (lock_lost)
      state_d = S_PLL_RST;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      match_q   <= '0;
      loss_q    <= '0;
      slip_q    <= '0;
      pll_rst_q <= 1'b1;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      dp_rst_q  <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pll_rst_q <= (state_d == S_PLL_RST);
      aligned_q <= (state_d == S_ALIGNED);
      dp_rst_q  <= (state_d != S_ALIGNED);
      bitslip_q <= (state_q == S_CHECK) && (state_d == S_SLIP) &&
                   (slip_q != 3'd7);

      if (state_d != state_q)
        cnt_q <= '0;
      else if (cnt_q != CW'(CMAX))
        cnt_q <= cnt_q + CW'(1);

      if (state_q == S_CHECK && match) begin
        if (match_q != MW'(P_MATCH_CNT))
          match_q <= match_q + MW'(1);
      end else begin
        match_q <= '0;
      end

      if (state_q == S_ALIGNED && !match) begin
        if (loss_q != LW'(P_LOSS_CNT))
          loss_q <= loss_q + LW'(1);
      end else begin
        loss_q <= '0;
      end

      if (state_d == S_PLL_RST)
        slip_q <= '0;
      else if (state_d == S_SLIP && slip_q != 3'd7)
        slip_q <= slip_q + 3'd1;

      if (state_q == S_SLIP && !bitslip_q)
        err_q <= 1'b1;
    end
  end

  assign O_pll_rst  = pll_rst_q;
  assign O_bitslip  = bitslip_q;
  assign O_aligned  = aligned_q;
  assign O_rst      = dp_rst_q;
  assign O_slip_cnt = slip_q;
  assign O_err      = err_q;

endmodule

// File: tb/tb_rx_align_ctrl.sv
// tb_rx_align_ctrl: scenario tasks plus randomized alignment runs
// checked against a timeline model of the alignment procedure.
module tb_rx_align_ctrl;
  localparam int RSTC   = 10;
  localparam int TMO    = 4096;
  localparam int MATCH  = 16;
  localparam int SETTLE = 4;
  localparam int LOSS   = 4;
  localparam logic [6:0] PAT = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic [6:0] word;
  logic       O_pll_rst, O_bitslip, O_aligned, O_rst, O_err;
  logic [2:0] O_slip_cnt;

  int npass = 0, ntot = 0;
  int nedge = 0, viol = 0, offset = 0, last_bs = -100;
  int bs_t[$];
  bit inj_en = 1'b0;
  logic [6:0] inj_word = 7'd0;

  always #5 clk = ~clk;

  rx_align_ctrl dut (
    .I_clk(clk), .I_rst(rst), .I_pll_lock(lock),
    .I_clk_word(word), .O_pll_rst(O_pll_rst),
    .O_bitslip(O_bitslip), .O_aligned(O_aligned),
    .O_rst(O_rst), .O_slip_cnt(O_slip_cnt), .O_err(O_err)
  );

  function automatic logic [6:0] rotl(input logic [6:0] w, input int n);
    logic [6:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
    return r;
  endfunction

  function automatic logic [6:0] bad_word();
    logic [6:0] w;
    w = 7'($urandom_range(0, 127));
    if (w == PAT) w = w ^ 7'd1;
    return w;
  endfunction

  // Word source: each bitslip undoes one bit of rotation
  assign word = inj_en ? inj_word : rotl(PAT, offset);

  always @(posedge clk) nedge++;

  always @(negedge clk) begin
    if (O_rst !== ~O_aligned) viol++;
    if (O_bitslip === 1'b1) begin
      if (nedge - last_bs < SETTLE + 2) viol++;
      last_bs = nedge;
      bs_t.push_back(nedge);
      offset = (offset + 6) % 7;
    end
  end

  task automatic wait_until(input int e);
    while (nedge < e) @(negedge clk);
  endtask

  task automatic start_up(input int off, input bit inj, output int t0);
    lock = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    offset = off;
    inj_en = inj;
    bs_t.delete();
    rst = 1'b0;
    t0 = nedge;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ntot++; if (O_pll_rst !== 1'b1) $display("FAIL rst_pll got %b exp 1", O_pll_rst); else npass++;
    ntot++; if (O_bitslip !== 1'b0) $display("FAIL rst_bitslip got %b exp 0", O_bitslip); else npass++;
    ntot++; if (O_aligned !== 1'b0) $display("FAIL rst_aligned got %b exp 0", O_aligned); else npass++;
    ntot++; if (O_rst !== 1'b1) $display("FAIL rst_orst got %b exp 1", O_rst); else npass++;
    ntot++; if (O_slip_cnt !== 3'd0) $display("FAIL rst_slipcnt got %0d exp 0", O_slip_cnt); else npass++;
    ntot++; if (O_err !== 1'b0) $display("FAIL rst_err got %b exp 0", O_err); else npass++;
  endtask

  task automatic test_nominal();
    int t0, L, hi;
    start_up(0, 1'b0, t0);
    hi = 0;
    for (int k = 0; k < RSTC; k++) begin
      wait_until(t0 + k);
      if (O_pll_rst === 1'b1) hi++;
    end
    ntot++; if (hi != RSTC) $display("FAIL nom_pll_high got %0d exp %0d", hi, RSTC); else npass++;
    wait_until(t0 + RSTC);
    ntot++; if (O_pll_rst !== 1'b0) $display("FAIL nom_pll_fall got %b exp 0", O_pll_rst); else npass++;
    wait_until(t0 + 20);
    lock = 1'b1;
    L = t0 + 21;
    wait_until(L + MATCH - 1);
    ntot++; if (O_aligned !== 1'b0) $display("FAIL nom_early_align got %b exp 0", O_aligned); else npass++;
    wait_until(L + MATCH);
    ntot++; if (O_aligned !== 1'b1) $display("FAIL nom_align got %b exp 1", O_aligned); else npass++;
    ntot++; if (O_slip_cnt !== 3'd0) $display("FAIL nom_slipcnt got %0d exp 0", O_slip_cnt); else npass++;
    ntot++; if (bs_t.size() != 0) $display("FAIL nom_no_slip got %0d exp 0", bs_t.size()); else npass++;
  endtask

  task automatic test_slip();
    int t0, L;
    start_up(3, 1'b0, t0);
    lock = 1'b1;
    L = t0 + RSTC + 1;
    wait_until(L + 3 * (SETTLE + 2) + MATCH - 1);
    ntot++; if (O_aligned !== 1'b0) $display("FAIL slip_early_align got %b exp 0", O_aligned); else npass++;
    wait_until(L + 3 * (SETTLE + 2) + MATCH);
    ntot++; if (O_aligned !== 1'b1) $display("FAIL slip_align got %b exp 1", O_aligned); else npass++;
    ntot++; if (O_slip_cnt !== 3'd3) $display("FAIL slip_cnt got %0d exp 3", O_slip_cnt); else npass++;
    ntot++; if (bs_t.size() != 3) $display("FAIL slip_pulses got %0d exp 3", bs_t.size()); else npass++;
    if (bs_t.size() == 3) begin
      ntot++; if (bs_t[0] != L + 1) $display("FAIL slip_first got %0d exp %0d", bs_t[0] - t0, L + 1 - t0); else npass++;
      for (int i = 0; i < 2; i++) begin
        ntot++;
        if (bs_t[i+1] - bs_t[i] - 1 != SETTLE + 1)
          $display("FAIL slip_gap idle got %0d exp %0d", bs_t[i+1] - bs_t[i] - 1, SETTLE + 1);
        else npass++;
      end
    end
  endtask

  task automatic test_noalign();
    int t0, L, hi;
    inj_word = 7'd0;
    start_up(0, 1'b1, t0);
    lock = 1'b1;
    L = t0 + RSTC + 1;
    wait_until(L + 7 * (SETTLE + 2) + 1);
    ntot++; if (bs_t.size() != 7) $display("FAIL noal_pulses got %0d exp 7", bs_t.size()); else npass++;
    ntot++; if (O_slip_cnt !== 3'd7) $display("FAIL noal_cnt7 got %0d exp 7", O_slip_cnt); else npass++;
    ntot++; if (O_err !== 1'b0) $display("FAIL noal_err_early got %b exp 0", O_err); else npass++;
    ntot++; if (O_bitslip !== 1'b0) $display("FAIL noal_8th_slip got %b exp 0", O_bitslip); else npass++;
    hi = 0;
    for (int k = 0; k < RSTC; k++) begin
      wait_until(L + 7 * (SETTLE + 2) + 2 + k);
      if (O_pll_rst === 1'b1) hi++;
      if (k == 0) begin
        ntot++; if (O_err !== 1'b1) $display("FAIL noal_err got %b exp 1", O_err); else npass++;
        ntot++; if (O_slip_cnt !== 3'd0) $display("FAIL noal_cnt0 got %0d exp 0", O_slip_cnt); else npass++;
      end
    end
    ntot++; if (hi != RSTC) $display("FAIL noal_pll_high got %0d exp %0d", hi, RSTC); else npass++;
    wait_until(L + 7 * (SETTLE + 2) + 2 + RSTC);
    ntot++; if (O_pll_rst !== 1'b0) $display("FAIL noal_pll_fall got %b exp 0", O_pll_rst); else npass++;
    ntot++; if (O_err !== 1'b1) $display("FAIL noal_err_sticky got %b exp 1", O_err); else npass++;
    inj_en = 1'b0;
  endtask

  task automatic test_lock_low();
    int t0, hi, al, nr;
    int rises[$];
    bit prev;
    start_up(0, 1'b0, t0);
    hi = 0; al = 0; prev = 1'b1;
    for (int k = 0; k <= 2 * (RSTC + TMO) + RSTC + 2; k++) begin
      wait_until(t0 + k);
      if (O_pll_rst === 1'b1) hi++;
      if (O_pll_rst === 1'b1 && !prev) rises.push_back(k);
      if (O_aligned !== 1'b0) al++;
      prev = (O_pll_rst === 1'b1);
    end
    nr = rises.size();
    ntot++; if (nr != 2) $display("FAIL ll_rises got %0d exp 2", nr); else npass++;
    if (nr == 2) begin
      ntot++; if (rises[0] != RSTC + TMO) $display("FAIL ll_first got %0d exp %0d", rises[0], RSTC + TMO); else npass++;
      ntot++; if (rises[1] - rises[0] != RSTC + TMO) $display("FAIL ll_period got %0d exp %0d", rises[1] - rises[0], RSTC + TMO); else npass++;
    end
    ntot++; if (hi != 3 * RSTC) $display("FAIL ll_high got %0d exp %0d", hi, 3 * RSTC); else npass++;
    ntot++; if (al != 0) $display("FAIL ll_aligned got %0d exp 0", al); else npass++;
  endtask

  task automatic align_now(output int t);
    int t0;
    start_up(0, 1'b0, t0);
    lock = 1'b1;
    wait_until(t0 + RSTC + 1 + MATCH);
    ntot++; if (O_aligned !== 1'b1) $display("FAIL pre_align got %b exp 1", O_aligned); else npass++;
    t = nedge;
  endtask

  task automatic test_loss();
    int t, t2, nbs, drop;
    align_now(t);
    inj_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_until(t + k);
      inj_word = bad_word();
    end
    wait_until(t + 3);
    inj_en = 1'b0;
    drop = 0;
    for (int k = 1; k <= 6; k++) begin
      wait_until(t + k);
      if (O_aligned !== 1'b1) drop++;
    end
    ntot++; if (drop != 0) $display("FAIL loss3_drops got %0d exp 0", drop); else npass++;
    t2 = nedge;
    nbs = bs_t.size();
    inj_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_until(t2 + k);
      inj_word = bad_word();
    end
    wait_until(t2 + 4);
    inj_en = 1'b0;
    ntot++; if (O_aligned !== 1'b0) $display("FAIL loss4_fall got %b exp 0", O_aligned); else npass++;
    ntot++; if (O_pll_rst !== 1'b0) $display("FAIL loss4_pll got %b exp 0", O_pll_rst); else npass++;
    wait_until(t2 + 4 + MATCH - 1);
    ntot++; if (O_aligned !== 1'b0) $display("FAIL loss4_early got %b exp 0", O_aligned); else npass++;
    wait_until(t2 + 4 + MATCH);
    ntot++; if (O_aligned !== 1'b1) $display("FAIL loss4_realign got %b exp 1", O_aligned); else npass++;
    ntot++; if (bs_t.size() != nbs) $display("FAIL loss4_slips got %0d exp %0d", bs_t.size(), nbs); else npass++;
  endtask

  task automatic test_lock_drop();
    int t;
    align_now(t);
    inj_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_until(t + k);
      inj_word = bad_word();
      if (k == 3) lock = 1'b0;
    end
    wait_until(t + 4);
    inj_en = 1'b0;
    ntot++; if (O_pll_rst !== 1'b1) $display("FAIL ld_pll got %b exp 1", O_pll_rst); else npass++;
    ntot++; if (O_aligned !== 1'b0) $display("FAIL ld_aligned got %b exp 0", O_aligned); else npass++;
    ntot++; if (O_rst !== 1'b1) $display("FAIL ld_orst got %b exp 1", O_rst); else npass++;
    lock = 1'b1;
  endtask

  task automatic test_reset_midslip();
    int t0, L, t1, t2, hi;
    start_up(3, 1'b0, t0);
    lock = 1'b1;
    L = t0 + RSTC + 1;
    wait_until(L);
    rst = 1'b1;
    wait_until(L + 1);
    ntot++; if (O_bitslip !== 1'b0) $display("FAIL mid_bitslip got %b exp 0", O_bitslip); else npass++;
    ntot++; if (O_pll_rst !== 1'b1) $display("FAIL mid_pll got %b exp 1", O_pll_rst); else npass++;
    wait_until(L + 3);
    ntot++; if (bs_t.size() != 0) $display("FAIL mid_pulses got %0d exp 0", bs_t.size()); else npass++;
    rst = 1'b0;
    t1 = nedge;
    wait_until(t1 + 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t2 = nedge;
    hi = 0;
    for (int k = 0; k < RSTC; k++) begin
      wait_until(t2 + k);
      if (O_pll_rst === 1'b1) hi++;
    end
    ntot++; if (hi != RSTC) $display("FAIL rerst_high got %0d exp %0d", hi, RSTC); else npass++;
    wait_until(t2 + RSTC);
    ntot++; if (O_pll_rst !== 1'b0) $display("FAIL rerst_fall got %b exp 0", O_pll_rst); else npass++;
  endtask

  task automatic test_random();
    int t0, off, d, L, A, run;
    bit mm, exp_al;
    for (int it = 0; it < 6; it++) begin
      off = $urandom_range(0, 6);
      d = $urandom_range(0, 25);
      start_up(off, 1'b0, t0);
      wait_until(t0 + d);
      lock = 1'b1;
      L = t0 + ((d + 1 > RSTC + 1) ? d + 1 : RSTC + 1);
      A = L + off * (SETTLE + 2) + MATCH;
      wait_until(A - 1);
      ntot++; if (O_aligned !== 1'b0) $display("FAIL rnd%0d_early got %b exp 0", it, O_aligned); else npass++;
      wait_until(A);
      ntot++; if (O_aligned !== 1'b1) $display("FAIL rnd%0d_align got %b exp 1", it, O_aligned); else npass++;
      ntot++; if (bs_t.size() != off) $display("FAIL rnd%0d_pulses got %0d exp %0d", it, bs_t.size(), off); else npass++;
      ntot++; if (O_slip_cnt !== 3'(off)) $display("FAIL rnd%0d_cnt got %0d exp %0d", it, O_slip_cnt, off); else npass++;
      ntot++; if (O_err !== 1'b0) $display("FAIL rnd%0d_err got %b exp 0", it, O_err); else npass++;
      run = 0;
      for (int j = 0; j < 30; j++) begin
        mm = ($urandom_range(0, 2) == 0);
        inj_word = bad_word();
        inj_en = mm;
        @(negedge clk);
        run = mm ? run + 1 : 0;
        exp_al = (run < LOSS);
        ntot++;
        if (O_aligned !== exp_al)
          $display("FAIL rnd%0d_stream%0d got %b exp %b", it, j, O_aligned, exp_al);
        else npass++;
        if (!exp_al) break;
      end
      inj_en = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_slip();
    test_noalign();
    test_lock_low();
    test_loss();
    test_lock_drop();
    test_reset_midslip();
    test_random();
    ntot++;
    if (viol != 0) $display("FAIL spacing_and_orst violations got %0d exp 0", viol);
    else npass++;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
